// File: rtl/axis_usb_tx_arbiter_pkg.sv
// Shared definitions for the USB TX stream arbiter: FSM states and framing words.
package axis_usb_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_TRAILER
  } state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  localparam logic [15:0] TRL_MAGIC = 16'h5AA5;

  function automatic logic [31:0] hdr_word(input logic [2:0] port);
    return {HDR_MAGIC, 13'd0, port};
  endfunction

  function automatic logic [31:0] trl_word(input logic [15:0] words);
    return {TRL_MAGIC, words};
  endfunction

endpackage

// File: rtl/axis_usb_tx_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: lowest set req bit at or above ptr, wrapping.
module rr_priority_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [3:0]   sum;

  // Rotate so bit 0 is the pointer position; scan downward so the nearest hit wins.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    sum   = '0;
    idx   = '0;
    found = |req;
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        sum = 4'(ptr) + 4'(i - 1);
        if (sum >= 4'(N)) begin
          sum = sum - 4'(N);
        end
        idx = sum[2:0];
      end
    end
  end

endmodule

// File: rtl/axis_usb_tx_arbiter.sv
// Packet-level round-robin arbiter framing NUM_PORTS AXI4-Stream sources onto one USB TX stream.
module axis_usb_tx_arbiter
  import axis_usb_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned BURST_LEN = 256
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [NUM_PORTS-1:0]    port_mask,
  input  logic [NUM_PORTS*32-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]    s_axis_tlast,
  output logic [NUM_PORTS-1:0]    s_axis_tready,
  output logic [31:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [2:0]              grant
);

  state_t         state, state_next;
  logic [2:0]     rr_ptr;
  logic [15:0]    count;
  logic [NUM_PORTS-1:0] req;
  logic [2:0]     pick_idx;
  logic           pick_found;
  logic [31:0]    sel_data;
  logic           sel_valid;
  logic           sel_last;
  logic           beat;
  logic           last_beat;

  assign req = s_axis_tvalid & port_mask;

  rr_priority_pick #(
    .N(NUM_PORTS)
  ) u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant == 3'(i)) begin
        sel_data  = s_axis_tdata[32*i +: 32];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // Tlast and burst-limit on the same beat both land here, so only one trailer results.
  assign beat      = (state == ST_DATA) && sel_valid && m_axis_tready;
  assign last_beat = beat && (sel_last || (count == 16'(BURST_LEN - 1)));
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_next    = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (state)
      ST_IDLE: begin
        if (pick_found) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        m_axis_tdata  = hdr_word(grant);
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_next = ST_DATA;
      end
      ST_DATA: begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = sel_valid;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (grant == 3'(i)) s_axis_tready[i] = m_axis_tready;
        end
        if (last_beat) state_next = ST_TRAILER;
      end
      ST_TRAILER: begin
        m_axis_tdata  = trl_word(count);
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      count  <= '0;
      grant  <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (pick_found) grant <= pick_idx;
        end
        ST_HEADER: begin
          if (m_axis_tready) count <= '0;
        end
        ST_DATA: begin
          if (beat) count <= count + 16'd1;
        end
        ST_TRAILER: begin
          if (m_axis_tready) rr_ptr <= (grant == 3'(NUM_PORTS - 1)) ? '0 : grant + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_usb_tx_arbiter.sv
// Self-checking bench for axis_usb_tx_arbiter: cycle table plus directed multi-cycle sequences.
module tb_axis_usb_tx_arbiter;

  localparam int NP = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [NP-1:0]   port_mask;
  logic [NP*32-1:0] s_data;
  logic [NP-1:0]   s_valid;
  logic [NP-1:0]   s_last;
  logic            m_ready;

  logic [NP-1:0]   sm_sready, bg_sready;
  logic [31:0]     sm_mdata, bg_mdata;
  logic            sm_mvalid, bg_mvalid, sm_busy, bg_busy;
  logic [2:0]      sm_grant, bg_grant;

  logic            use_big;
  logic [31:0]     mdata;
  logic            mvalid, busy;
  logic [NP-1:0]   sready;
  logic [2:0]      grant;

  assign mdata  = use_big ? bg_mdata  : sm_mdata;
  assign mvalid = use_big ? bg_mvalid : sm_mvalid;
  assign busy   = use_big ? bg_busy   : sm_busy;
  assign sready = use_big ? bg_sready : sm_sready;
  assign grant  = use_big ? bg_grant  : sm_grant;

  always #5 aclk = ~aclk;

  axis_usb_tx_arbiter #(.NUM_PORTS(NP), .BURST_LEN(4)) u_small (
    .aclk(aclk), .areset(areset), .port_mask(port_mask),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(sm_sready), .m_axis_tdata(sm_mdata), .m_axis_tvalid(sm_mvalid),
    .m_axis_tready(m_ready), .busy(sm_busy), .grant(sm_grant)
  );

  axis_usb_tx_arbiter #(.NUM_PORTS(NP), .BURST_LEN(256)) u_big (
    .aclk(aclk), .areset(areset), .port_mask(port_mask),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(bg_sready), .m_axis_tdata(bg_mdata), .m_axis_tvalid(bg_mvalid),
    .m_axis_tready(m_ready), .busy(bg_busy), .grant(bg_grant)
  );

  int checks = 0;
  int errors = 0;

  logic [32:0] srcq [NP][$];
  logic [31:0] outq [$];
  logic [31:0] expq [$];
  logic        rand_ready, stab_en, prev_stall;
  logic [31:0] prev_data;

  typedef struct {
    logic        tv;
    logic        tl;
    logic [31:0] td;
    logic        mr;
    logic        busy;
    logic        mv;
    logic [31:0] md;
    logic        sr;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    logic [32:0] w;
    for (int i = 0; i < NP; i++) begin
      s_valid[i] = srcq[i].size() > 0;
      w = s_valid[i] ? srcq[i][0] : 33'h0;
      s_data[32*i +: 32] = w[31:0];
      s_last[i] = w[32];
    end
  endtask

  task automatic add_pkt(input int p, input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) srcq[p].push_back({k == n - 1, base + 32'(k)});
    drive_src();
  endtask

  task automatic cyc();
    logic [NP-1:0] pop;
    @(negedge aclk);
    if (stab_en && prev_stall) begin
      check("hold_valid", 32'(mvalid), 32'd1);
      check("hold_data", mdata, prev_data);
    end
    prev_stall = mvalid && !m_ready;
    prev_data  = mdata;
    if (mvalid && m_ready) outq.push_back(mdata);
    pop = s_valid & sready;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NP; i++) if (pop[i]) void'(srcq[i].pop_front());
    drive_src();
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cyc();
  endtask

  task automatic wait_out(input int n, input int maxc, input string name);
    int c = 0;
    while (outq.size() < n && c < maxc) begin
      cyc();
      c++;
    end
    checks++;
    if (outq.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d words expected %0d", name, outq.size(), n);
    end
  endtask

  task automatic expect_out(input string name);
    check($sformatf("%s_len", name), 32'(outq.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size() && k < outq.size(); k++)
      check($sformatf("%s[%0d]", name, k), outq[k], expq[k]);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    for (int i = 0; i < NP; i++) srcq[i].delete();
    drive_src();
    outq.delete();
    expq.delete();
    prev_stall = 1'b0;
    rand_ready = 1'b0;
    stab_en    = 1'b0;
    m_ready    = 1'b1;
    port_mask  = '1;
    @(posedge aclk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mvalid", 32'(mvalid), 32'd0);
    check("rst_sready", 32'(sready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    use_big = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;

    // Port 0, three words, with a header stall, source gap and trailer stall.
    tbl[0]  = '{1'b1, 1'b0, 32'hD000_0000, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'hD000_0000, 1'b0, 1'b1, 1'b1, 32'hA55A_0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'hD000_0000, 1'b1, 1'b1, 1'b1, 32'hA55A_0000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'hD000_0000, 1'b1, 1'b1, 1'b1, 32'hD000_0000, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 32'hD000_0001, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'hD000_0001, 1'b0, 1'b1, 1'b1, 32'hD000_0001, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'hD000_0001, 1'b1, 1'b1, 1'b1, 32'hD000_0001, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 32'hD000_0002, 1'b1, 1'b1, 1'b1, 32'hD000_0002, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h5AA5_0003, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h5AA5_0003, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0};

    do_reset();
    for (int r = 0; r < 11; r++) begin
      s_valid = {3'b0, tbl[r].tv};
      s_last  = {3'b0, tbl[r].tl};
      s_data  = {96'h0, tbl[r].td};
      m_ready = tbl[r].mr;
      @(negedge aclk);
      check($sformatf("t1_busy[%0d]", r), 32'(sm_busy), 32'(tbl[r].busy));
      check($sformatf("t1_mvalid[%0d]", r), 32'(sm_mvalid), 32'(tbl[r].mv));
      check($sformatf("t1_sready[%0d]", r), 32'(sm_sready), {31'h0, tbl[r].sr});
      if (tbl[r].mv) check($sformatf("t1_mdata[%0d]", r), sm_mdata, tbl[r].md);
      if (tbl[r].busy) check($sformatf("t1_grant[%0d]", r), 32'(sm_grant), 32'd0);
      @(posedge aclk);
      #1;
    end

    // BURST_LEN=4: six-word packet on port 1 splits into 4 + 2.
    do_reset();
    add_pkt(1, 6, 32'h1100_0000);
    run(40);
    expq = '{32'hA55A_0001, 32'h1100_0000, 32'h1100_0001, 32'h1100_0002, 32'h1100_0003,
             32'h5AA5_0004, 32'hA55A_0001, 32'h1100_0004, 32'h1100_0005, 32'h5AA5_0002};
    expect_out("split");
    check("split_busy", 32'(busy), 32'd0);

    // All ports requesting one-word packets: strict rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int p = 0; p < NP; p++) add_pkt(p, 1, 32'h3000_0000 + 32'(p << 8));
    for (int p = 0; p < NP; p++) add_pkt(p, 1, 32'h3000_0001 + 32'(p << 8));
    run(50);
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < NP; p++) begin
        expq.push_back(32'hA55A_0000 + 32'(p));
        expq.push_back(32'h3000_0000 + 32'(p << 8) + 32'(g));
        expq.push_back(32'h5AA5_0001);
      end
    expect_out("rr");

    // Random sink backpressure over a 10-word burst on the 256-word instance.
    use_big = 1'b1;
    do_reset();
    rand_ready = 1'b1;
    stab_en    = 1'b1;
    add_pkt(2, 10, 32'h2200_0000);
    run(200);
    rand_ready = 1'b0;
    stab_en    = 1'b0;
    m_ready    = 1'b1;
    run(4);
    expq.push_back(32'hA55A_0002);
    for (int k = 0; k < 10; k++) expq.push_back(32'h2200_0000 + 32'(k));
    expq.push_back(32'h5AA5_000A);
    expect_out("bp");

    // Mask 1010; dropping port 1 mid-burst must not abort it.
    use_big = 1'b0;
    do_reset();
    port_mask = 4'b1010;
    for (int p = 0; p < NP; p++) add_pkt(p, 3, 32'h5000_0000 + 32'(p << 8));
    wait_out(2, 50, "mask_start");
    port_mask = 4'b1000;
    run(40);
    expq = '{32'hA55A_0001, 32'h5000_0100, 32'h5000_0101, 32'h5000_0102, 32'h5AA5_0003,
             32'hA55A_0003, 32'h5000_0300, 32'h5000_0301, 32'h5000_0302, 32'h5AA5_0003};
    expect_out("mask");
    check("mask_p0_left", 32'(srcq[0].size()), 32'd3);
    check("mask_p2_left", 32'(srcq[2].size()), 32'd3);
    check("mask_busy", 32'(busy), 32'd0);

    // Reset while word 5 of a burst is on the bus; pointer must return to 0.
    use_big = 1'b1;
    do_reset();
    add_pkt(2, 1, 32'h6200_0000);
    wait_out(3, 30, "rst_pre");
    add_pkt(3, 10, 32'h6300_0000);
    wait_out(8, 40, "rst_burst");
    @(negedge aclk);
    check("rst_w5_valid", 32'(mvalid), 32'd1);
    check("rst_w5_data", mdata, 32'h6300_0004);
    #1;
    areset = 1'b1;
    #1;
    check("mid_rst_mvalid", 32'(mvalid), 32'd0);
    check("mid_rst_sready", 32'(sready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    outq.delete();
    prev_stall = 1'b0;
    add_pkt(0, 1, 32'h6000_0000);
    wait_out(1, 30, "post_rst");
    check("post_rst_hdr", outq.size() > 0 ? outq[0] : 32'h0, 32'hA55A_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
